// File: rtl/fpu_cmp_serial_2b.sv
// ---------------------------------------------------------------------------
// fpu_cmp_serial_2b
// Multi-cycle unsigned magnitude comparator for FPU operands. Operands are
// scanned two bits per cycle starting at the MSB slice; the first differing
// slice decides the result.
//
// Configuration macro:
//   FPU_CMP_EARLY_EXIT_EN  defined   : scan stops at the first differing slice
//                          undefined : scan always covers all WIDTH/2 slices
//                                      (constant latency, identical results)
//
// Parameters:
//   WIDTH          operand width, even and >= 2 (N = WIDTH/2 slices)
// Ports:
//   rclk           clock, all state on the rising edge
//   reset          synchronous active-high reset
//   start_vld      compare request
//   start_rdy      idle; request accepted this cycle when start_vld=1
//   din1, din2     operands, sampled only on accept
//   busy           comparison in progress
//   cmp_done       one-cycle pulse, results valid
//   din2_gt_din1   din2 > din1
//   din1_gt_din2   din1 > din2
//   din2_neq_din1  din2 != din1
// ---------------------------------------------------------------------------
module fpu_cmp_serial_2b #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             start_vld,
    output logic             start_rdy,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    output logic             busy,
    output logic             cmp_done,
    output logic             din2_gt_din1,
    output logic             din1_gt_din2,
    output logic             din2_neq_din1
);

    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    logic               g21_q, g21_d;
    logic               g12_q, g12_d;
    logic               neq_q, neq_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifndef FPU_CMP_EARLY_EXIT_EN
    // First difference seen during a constant-latency scan.
    logic               rec_vld_q, rec_vld_d;
    logic               rec_g21_q, rec_g21_d;
    logic               rec_g12_q, rec_g12_d;
`endif

    logic [1:0]         slice1_c;
    logic [1:0]         slice2_c;
    logic               slice_gt_c;
    logic               slice_lt_c;
    logic               slice_neq_c;
    logic               last_slice_c;

    // Current 2-bit slice of each operand, bits [2*idx+1 : 2*idx].
    assign slice1_c = 2'(op1_q >> {idx_q, 1'b0});
    assign slice2_c = 2'(op2_q >> {idx_q, 1'b0});

    // Slice compare: gt means din2 slice > din1 slice, lt the reverse.
    assign slice_gt_c = (~slice1_c[1] & slice2_c[1]) |
                        (~(slice1_c[1] ^ slice2_c[1]) & ~slice1_c[0] & slice2_c[0]);
    assign slice_lt_c = (~slice2_c[1] & slice1_c[1]) |
                        (~(slice1_c[1] ^ slice2_c[1]) & ~slice2_c[0] & slice1_c[0]);
    assign slice_neq_c  = slice_gt_c | slice_lt_c;
    assign last_slice_c = (idx_q == IDX_W'(0));

    // State register.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_vld) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
`ifdef FPU_CMP_EARLY_EXIT_EN
                if (slice_neq_c || last_slice_c) begin
                    state_d = ST_DONE;
                end
`else
                if (last_slice_c) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        idx_d = idx_q;
        op1_d = op1_q;
        op2_d = op2_q;
        g21_d = g21_q;
        g12_d = g12_q;
`ifndef FPU_CMP_EARLY_EXIT_EN
        rec_vld_d = rec_vld_q;
        rec_g21_d = rec_g21_q;
        rec_g12_d = rec_g12_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_vld) begin
                    op1_d = din1;
                    op2_d = din2;
                    idx_d = IDX_MAX;
                    g21_d = 1'b0;
                    g12_d = 1'b0;
`ifndef FPU_CMP_EARLY_EXIT_EN
                    rec_vld_d = 1'b0;
                    rec_g21_d = 1'b0;
                    rec_g12_d = 1'b0;
`endif
                end
            end
            ST_SCAN: begin
                if (!last_slice_c) begin
                    idx_d = idx_q - IDX_W'(1);
                end
`ifdef FPU_CMP_EARLY_EXIT_EN
                // Equal operands leave the flags at their cleared value.
                if (slice_neq_c) begin
                    g21_d = slice_gt_c;
                    g12_d = slice_lt_c;
                end
`else
                // Only the most significant difference counts.
                if (!rec_vld_q && slice_neq_c) begin
                    rec_vld_d = 1'b1;
                    rec_g21_d = slice_gt_c;
                    rec_g12_d = slice_lt_c;
                end
                // Publish the result only when DONE is entered.
                if (last_slice_c) begin
                    g21_d = rec_vld_q ? rec_g21_q : slice_gt_c;
                    g12_d = rec_vld_q ? rec_g12_q : slice_lt_c;
                end
`endif
            end
            default: begin
            end
        endcase
        neq_d  = g21_d | g12_d;
        rdy_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Control, index and result registers.
    always_ff @(posedge rclk) begin
        if (reset) begin
            idx_q     <= IDX_MAX;
            g21_q     <= 1'b0;
            g12_q     <= 1'b0;
            neq_q     <= 1'b0;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef FPU_CMP_EARLY_EXIT_EN
            rec_vld_q <= 1'b0;
            rec_g21_q <= 1'b0;
            rec_g12_q <= 1'b0;
`endif
        end else begin
            idx_q     <= idx_d;
            g21_q     <= g21_d;
            g12_q     <= g12_d;
            neq_q     <= neq_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifndef FPU_CMP_EARLY_EXIT_EN
            rec_vld_q <= rec_vld_d;
            rec_g21_q <= rec_g21_d;
            rec_g12_q <= rec_g12_d;
`endif
        end
    end

    // Operand registers need no reset; they are loaded on every accept.
    always_ff @(posedge rclk) begin
        op1_q <= op1_d;
        op2_q <= op2_d;
    end

    assign start_rdy     = rdy_q;
    assign busy          = busy_q;
    assign cmp_done      = done_q;
    assign din2_gt_din1  = g21_q;
    assign din1_gt_din2  = g12_q;
    assign din2_neq_din1 = neq_q;

endmodule

// File: doc/fpu_cmp_serial_2b.md
# fpu_cmp_serial_2b

Multi-cycle magnitude comparator for FPU operands. It scans two WIDTH-bit unsigned operands 2 bits per cycle, starting at the MSB. It reports din2 > din1, din1 > din2 and inequality once the first differing 2-bit slice is found or all slices are exhausted. It sits beside the exponent/fraction datapath in the FPU compare/min-max path, where a full-width single-cycle comparator is not timing-friendly.

## Interface
Parameters:
- WIDTH, 64, operand width in bits; must be even and ≥ 2; N = WIDTH/2 slices.

Ports:
- rclk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_vld  in  1  request to compare din1/din2.
- start_rdy  out  1  block idle, request accepted this cycle if start_vld=1.
- din1  in  WIDTH  operand 1, sampled only on accept.
- din2  in  WIDTH  operand 2, sampled only on accept.
- busy  out  1  comparison in progress (state ≠ IDLE).
- cmp_done  out  1  one-cycle pulse; result valid.
- din2_gt_din1  out  1  result: din2 > din1 (unsigned).
- din1_gt_din2  out  1  result: din1 > din2 (unsigned).
- din2_neq_din1  out  1  result: din2 ≠ din1.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start_rdy=1. On start_vld:
  - latch din1/din2 into operand registers;
  - set slice index idx = N-1;
  - clear the result registers;
  - go to SCAN.
- SCAN: each edge examines slice idx, bits [2*idx+1 : 2*idx] of both operands.
  - Slice gt: (!a[1] & b[1]) | (a[1]~^b[1] & !a[0] & b[0]), with a = din1 slice and b = din2 slice; symmetric for lt.
  - Slice differs: set din2_neq_din1=1, set the gt flag for whichever operand is larger, go to DONE.
  - Slice equal and idx=0: all result flags stay 0 (operands equal), go to DONE.
  - Otherwise: idx ← idx-1.
- DONE: cmp_done=1 for exactly this cycle, then IDLE on the next edge. start_rdy=0 in DONE.
- Result flags hold their value from DONE until the next accepted start, which clears them.
- At most one of din2_gt_din1 / din1_gt_din2 is ever 1. din2_neq_din1 = OR of the two.
- start_vld while busy is ignored (no queuing). din1/din2 changes after accept have no effect.
- idx is ceil(log2(N)) bits wide, minimum 1. Underflow below 0 never occurs.

## Timing
- Reset values: state=IDLE, start_rdy=1, busy=0, cmp_done=0, all result flags=0, idx=N-1. Operand registers don't-care.
- Reset asserted mid-SCAN or in DONE: next edge returns to IDLE with all outputs at reset values. No cmp_done is issued for the aborted request.
- Accept at edge E0. With the first differing slice k positions below the MSB slice (k=0..N-1):
  - DONE is entered at edge E(k+1);
  - cmp_done is high during the cycle following E(k+1).
- Equal operands: cmp_done follows edge E(N).
- Next accept is possible at the edge ending the DONE cycle + 1, i.e. start_rdy returns one cycle after cmp_done.
- Worst-case accept-to-accept interval: N+2 cycles.
- reset has priority over start_vld in the same cycle.

## Configuration
- FPU_CMP_EARLY_EXIT_EN defined: SCAN terminates at the first differing slice, giving latency k+1 as above.
- Undefined: constant latency. SCAN always runs all N slices.
  - The first differing slice's result is latched.
  - Later slices are ignored once a difference has been recorded.
  - DONE is always entered at edge E(N).
  - Final result values are identical in both builds.

## Test plan
WIDTH=8, N=4.
- Reset: hold reset 2 cycles during SCAN of din1=8'h00, din2=8'hFF → no cmp_done; start_rdy=1, busy=0, all flags 0.
- MSB difference: din1=8'h40, din2=8'h80 → din2_gt_din1=1, din2_neq_din1=1, din1_gt_din2=0.
  - Early exit: cmp_done 1 cycle after E1.
  - Constant latency: cmp_done after E4.
- LSB difference: din1=8'h03, din2=8'h02 → din1_gt_din2=1, din2_neq_din1=1; cmp_done after E4 in both builds.
- Equal operands: din1=din2=8'hA5 → all flags 0 after E4; flags from the previous comparison are cleared at accept.
- Busy rejection: a second start_vld with din2=8'h00 while in SCAN → ignored; the first result is unaltered; start_rdy=0 until the cycle after cmp_done.
- Back-to-back: start_vld held high → accepts exactly every (latency+2) cycles; each cmp_done pulse is one cycle wide.
